// File: rtl/ps2_codes_pkg.sv
// PS/2 set-2 scancode constants, mode-select key table and prefix-parser types
// shared by the mode selector and its prefix FSM.
package ps2_codes_pkg;

  localparam logic [7:0] KEY_BREAK = 8'hF0;
  localparam logic [7:0] KEY_EXT   = 8'hE0;
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;

  // F5..F12 select modes 1..8
  localparam logic [0:7][7:0] MODE_KEYS = {
    8'h03, 8'h0B, 8'h83, 8'h0A, 8'h01, 8'h09, 8'h78, 8'h07
  };

  typedef enum logic [1:0] {
    IDLE,
    BREAK,
    EXT,
    EXT_BREAK
  } prefix_state_t;

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } key_event_t;

endpackage

// File: rtl/ps2_prefix_fsm.sv
// Strips F0/E0 prefixes from the PS/2 byte stream and emits one key event per
// complete sequence; an abandoned prefix is dropped after TIMEOUT_CYCLES.
module ps2_prefix_fsm
  import ps2_codes_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scancode,
  input  logic       scancode_valid,
  output key_event_t evt_c,
  output logic       evt_valid_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  prefix_state_t    state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // A valid byte always wins over timeout expiry in the same cycle
  always_comb begin
    state_d     = state;
    cnt_d       = '0;
    evt_valid_c = 1'b0;
    evt_c       = '{brk: 1'b0, ext: 1'b0, code: scancode};
    if (scancode_valid) begin
      case (state)
        IDLE: begin
          if (scancode == KEY_BREAK)    state_d = BREAK;
          else if (scancode == KEY_EXT) state_d = EXT;
          else                          evt_valid_c = 1'b1;
        end
        BREAK: begin
          evt_valid_c = 1'b1;
          evt_c.brk   = 1'b1;
          state_d     = IDLE;
        end
        EXT: begin
          if (scancode == KEY_BREAK) begin
            state_d = EXT_BREAK;
          end else begin
            evt_valid_c = 1'b1;
            evt_c.ext   = 1'b1;
            state_d     = IDLE;
          end
        end
        EXT_BREAK: begin
          evt_valid_c = 1'b1;
          evt_c.brk   = 1'b1;
          evt_c.ext   = 1'b1;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state != IDLE) begin
      if (cnt == TO_LAST) state_d = IDLE;
      else                cnt_d   = cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mode_select_ps2.sv
// Mode register 1..NUM_MODES driven by PS/2 function keys (direct select) and
// extended up/down arrows (step), with typematic suppression and change strobe.
module mode_select_ps2
  import ps2_codes_pkg::*;
#(
  parameter int unsigned NUM_MODES      = 3,
  parameter int unsigned RESET_MODE     = 1,
  parameter int unsigned WRAP           = 0,
  parameter int unsigned STEP_ON_REPEAT = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  localparam int unsigned MODE_W        = $clog2(NUM_MODES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        scancode,
  input  logic              scancode_valid,
  output logic [MODE_W-1:0] mode,
  output logic              mode_changed
);

  localparam logic [MODE_W-1:0] MAX_MODE = MODE_W'(NUM_MODES);
  localparam logic [MODE_W-1:0] MIN_MODE = MODE_W'(1);
  localparam logic              REPEAT_OK = (STEP_ON_REPEAT != 0);

  key_event_t        evt_c;
  logic              evt_valid_c;
  logic [MODE_W-1:0] mode_d;
  logic              up_held, up_held_d;
  logic              down_held, down_held_d;

  ps2_prefix_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_prefix (
    .clk           (clk),
    .reset         (reset),
    .scancode      (scancode),
    .scancode_valid(scancode_valid),
    .evt_c         (evt_c),
    .evt_valid_c   (evt_valid_c)
  );

  always_comb begin
    mode_d      = mode;
    up_held_d   = up_held;
    down_held_d = down_held;
    if (evt_valid_c) begin
      if (!evt_c.brk && !evt_c.ext) begin
        for (int unsigned k = 0; k < NUM_MODES; k++) begin
          if (evt_c.code == MODE_KEYS[3'(k)]) mode_d = MODE_W'(k + 1);
        end
      end else if (!evt_c.brk && evt_c.ext) begin
        // A saturated step still marks the key as held
        if (evt_c.code == KEY_UP && (REPEAT_OK || !up_held)) begin
          up_held_d = 1'b1;
          if (mode == MAX_MODE) mode_d = (WRAP != 0) ? MIN_MODE : MAX_MODE;
          else                  mode_d = mode + MODE_W'(1);
        end else if (evt_c.code == KEY_DOWN && (REPEAT_OK || !down_held)) begin
          down_held_d = 1'b1;
          if (mode == MIN_MODE) mode_d = (WRAP != 0) ? MAX_MODE : MIN_MODE;
          else                  mode_d = mode - MODE_W'(1);
        end
      end else if (evt_c.brk && evt_c.ext) begin
        if (evt_c.code == KEY_UP)   up_held_d   = 1'b0;
        if (evt_c.code == KEY_DOWN) down_held_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode         <= MODE_W'(RESET_MODE);
      mode_changed <= 1'b0;
      up_held      <= 1'b0;
      down_held    <= 1'b0;
    end else begin
      mode         <= mode_d;
      mode_changed <= (mode_d != mode);
      up_held      <= up_held_d;
      down_held    <= down_held_d;
    end
  end

endmodule
